// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/multu/div/divu into HI/LO,
// plus single-cycle mthi/mtlo writes. busy stalls md-class instructions in D.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [31:0]       ph, pl, ph_nx, pl_nx, hi_nx, lo_nx;
    logic              busy_nx;

    logic signed [31:0] sa, sb;
    logic [63:0]        prod_s, prod_u, res;
    logic               div_zero, div_ovf;

    assign sa       = a;
    assign sb       = b;
    assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u   = {32'b0, a} * {32'b0, b};
    assign div_zero = (b == 32'h0);
    // The only signed quotient that does not fit in 32 bits; wraps to INT_MIN.
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Full 64-bit result as {hi, lo}, evaluated from the start-cycle operands.
    always_comb begin
        res = 64'h0;
        case (op)
            3'd0: res = prod_s;
            3'd1: res = prod_u;
            3'd2: begin
                if (div_zero)     res = {a, 32'hFFFF_FFFF};
                else if (div_ovf) res = {32'h0, 32'h8000_0000};
                else              res = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (div_zero) res = {a, 32'hFFFF_FFFF};
                else          res = {a % b, a / b};
            end
            default: res = 64'h0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ph_nx    = ph;
        pl_nx    = pl;
        hi_nx    = hi;
        lo_nx    = lo;
        busy_nx  = busy;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            {ph_nx, pl_nx} = res;
                            cnt_nx   = CNT_W'(MULT_CYCLES);
                            state_nx = RUN;
                            busy_nx  = 1'b1;
                        end
                        3'd2, 3'd3: begin
                            {ph_nx, pl_nx} = res;
                            cnt_nx   = CNT_W'(DIV_CYCLES);
                            state_nx = RUN;
                            busy_nx  = 1'b1;
                        end
                        3'd4: hi_nx = a;
                        3'd5: lo_nx = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // start is deliberately ignored here; the hazard unit keeps it low.
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_nx    = ph;
                    lo_nx    = pl;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            ph    <= 32'h0;
            pl    <= 32'h0;
            hi    <= 32'h0;
            lo    <= 32'h0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ph    <= ph_nx;
            pl    <= pl_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
            busy  <= busy_nx;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed + randomized check of e_mdu against a 64-bit arithmetic reference model.
module tb_e_mdu;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, expv);
        end
    endtask

    // Reference: results straight from 64-bit integer arithmetic.
    task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] nhi, output logic [31:0] nlo, output int lat);
        longint q, r, p;
        longint unsigned pu, qu, ru;
        nhi = exp_hi;
        nlo = exp_lo;
        lat = 0;
        case (mop)
            3'd0: begin
                p = longint'($signed(ma)) * longint'($signed(mb));
                nhi = p[63:32]; nlo = p[31:0]; lat = MULT_CYCLES;
            end
            3'd1: begin
                pu = longint'(ma) * longint'(mb);
                nhi = pu[63:32]; nlo = pu[31:0]; lat = MULT_CYCLES;
            end
            3'd2: begin
                lat = DIV_CYCLES;
                if (mb == 0) begin nhi = ma; nlo = 32'hFFFF_FFFF; end
                else begin
                    q = longint'($signed(ma)) / longint'($signed(mb));
                    r = longint'($signed(ma)) % longint'($signed(mb));
                    nhi = r[31:0]; nlo = q[31:0];
                end
            end
            3'd3: begin
                lat = DIV_CYCLES;
                if (mb == 0) begin nhi = ma; nlo = 32'hFFFF_FFFF; end
                else begin
                    qu = longint'(ma) / longint'(mb);
                    ru = longint'(ma) % longint'(mb);
                    nhi = ru[31:0]; nlo = qu[31:0];
                end
            end
            3'd4: nhi = ma;
            3'd5: nlo = ma;
            default: ;
        endcase
    endtask

    // Count cycles busy stays high after the start edge, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] dop, input logic [31:0] da,
                         input logic [31:0] db);
        logic [31:0] nhi, nlo;
        int lat, cyc;
        model(dop, da, db, nhi, nlo, lat);
        @(negedge clk);
        start = 1'b1; op = dop; a = da; b = db;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        if (lat == 0) begin
            check({tag, ".busy"}, 32'(busy), 32'h0);
        end else begin
            check({tag, ".hold_hi"}, hi, exp_hi);
            check({tag, ".hold_lo"}, lo, exp_lo);
            wait_done(cyc);
            check({tag, ".lat"}, 32'(cyc), 32'(lat));
        end
        exp_hi = nhi; exp_lo = nlo;
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
    endtask

    initial begin
        logic [31:0] nhi, nlo, ra, rb;
        logic [2:0]  rop;
        int lat, cyc;

        reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
        #12;
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.hi", hi, 32'h0);
        check("rst.lo", lo, 32'h0);
        @(negedge clk); reset = 1'b1;

        do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult.const_hi", hi, 32'hFFFF_FFFF);
        check("mult.const_lo", lo, 32'hFFFF_FFFA);
        do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
        check("multu.const_hi", hi, 32'h2);
        do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div.const_lo", lo, 32'hFFFF_FFFD);
        check("div.const_hi", hi, 32'hFFFF_FFFF);
        do_op("divu0", 3'd3, 32'd7, 32'd0);
        check("divu0.const_lo", lo, 32'hFFFF_FFFF);
        do_op("div0", 3'd2, 32'hFFFF_FF00, 32'd0);
        do_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf.const_lo", lo, 32'h8000_0000);
        check("divovf.const_hi", hi, 32'h0);

        // Asynchronous reset mid-cycle, then idle.
        @(posedge clk); #3;
        reset = 1'b0; #1;
        exp_hi = 32'h0; exp_lo = 32'h0;
        check("arst.busy", 32'(busy), 32'h0);
        check("arst.hi", hi, 32'h0);
        check("arst.lo", lo, 32'h0);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle.hi", hi, 32'h0);
        check("idle.lo", lo, 32'h0);
        check("idle.busy", 32'(busy), 32'h0);

        do_op("mthi", 3'd4, 32'h1234, 32'h0);
        do_op("mtlo", 3'd5, 32'h5678, 32'h0);
        check("mtx.hi", hi, 32'h1234);
        check("mtx.lo", lo, 32'h5678);
        do_op("nop6", 3'd6, 32'hAAAA_AAAA, 32'h5);
        do_op("nop7", 3'd7, 32'hBBBB_BBBB, 32'h0);

        // Protocol violation: mtlo issued while a mult is running must be dropped.
        model(3'd0, 32'h0001_0003, 32'h0002_0005, nhi, nlo, lat);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'h0001_0003; b = 32'h0002_0005;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        $display("note: protocol error injected (start while busy)");
        start = 1'b1; op = 3'd5; a = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        check("ignore.lat", 32'(cyc + 2), 32'(MULT_CYCLES));
        exp_hi = nhi; exp_lo = nlo;
        check("ignore.hi", hi, exp_hi);
        check("ignore.lo", lo, exp_lo);

        // Reset aborts a running divide.
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0; #1;
        exp_hi = 32'h0; exp_lo = 32'h0;
        check("abort.busy", 32'(busy), 32'h0);
        check("abort.hi", hi, 32'h0);
        check("abort.lo", lo, 32'h0);
        @(negedge clk); reset = 1'b1;
        repeat (DIV_CYCLES) @(posedge clk);
        #1;
        check("abort.stay_hi", hi, 32'h0);
        check("abort.stay_lo", lo, 32'h0);
        do_op("post_abort", 3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            do_op("rand", rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
